microsequencer: RTL and testbench

Parametrised next-address microsequencer for the sol-1 core control unit, generalising the fixed 256×64 microcode layout to configurable opcode count, steps per instruction, page count and condition width. It registers the current micro-address, consumes the sequencing fields of the control word read combinationally from the microcode ROM at that address, and decides the next micro-address. Decision sources are sequential step, conditional relative branch, fetch/trap, or opcode dispatch. An optional micro-subroutine call/return stack is available.

---
 rtl/microsequencer.sv | 185 ++++++++++++++++++
 tb/tb_microsequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
// Next-address microsequencer: registers the micro-address and picks step, branch, fetch/trap or dispatch.
// Define MICROSEQ_CALL_STACK_EN to build the micro-subroutine call/return stack.
module microsequencer #(
    parameter int CYCLES_PER_INSTRUCTION = 64,
    parameter int NBR_INSTRUCTIONS       = 256,
    parameter int NBR_PAGES              = 2,
    parameter int OFFSET_W               = 7,
    parameter int COND_SEL_W             = 4,
    parameter int STACK_DEPTH            = 4,
    parameter int FETCH_U_ADDR           = 16,
    parameter int TRAP_U_ADDR            = 32,
    localparam int U_ADDR_W  = $clog2(NBR_PAGES * NBR_INSTRUCTIONS * CYCLES_PER_INSTRUCTION),
    localparam int IR_W      = $clog2(NBR_INSTRUCTIONS),
    localparam int FLAGS_W   = 2 ** COND_SEL_W,
    localparam int STK_LVL_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic [1:0]            typ_i,
    input  logic [OFFSET_W-1:0]   offset_i,
    input  logic                  cond_invert_i,
    input  logic                  cond_flag_src_i,
    input  logic [COND_SEL_W-1:0] cond_sel_i,
    input  logic                  escape_i,
    input  logic [IR_W-1:0]       ir_i,
    input  logic [FLAGS_W-1:0]    cpu_flags_i,
    input  logic [FLAGS_W-1:0]    u_flags_i,
    input  logic                  irq_pending_i,
    output logic [U_ADDR_W-1:0]   u_addr_o,
    output logic                  fetch_strobe_o,
    output logic                  trap_taken_o,
    output logic [STK_LVL_W-1:0]  stk_level_o,
    output logic                  stk_ovf_o,
    output logic                  stk_unf_o
);

    typedef enum logic [1:0] {
        SEQ_NEXT     = 2'b00,
        SEQ_BRANCH   = 2'b01,
        SEQ_FETCH    = 2'b10,
        SEQ_DISPATCH = 2'b11
    } seq_typ_e;

    localparam int STEP_W = $clog2(CYCLES_PER_INSTRUCTION);
    localparam logic [U_ADDR_W-1:0] FETCH_ADDR = U_ADDR_W'(FETCH_U_ADDR);
    localparam logic [U_ADDR_W-1:0] TRAP_ADDR  = U_ADDR_W'(TRAP_U_ADDR);
    localparam logic [U_ADDR_W-1:0] PAGE1_BASE = U_ADDR_W'(NBR_INSTRUCTIONS * CYCLES_PER_INSTRUCTION);

    seq_typ_e              typ;
    logic [U_ADDR_W-1:0]   u_addr_q, u_addr_d;
    logic                  fetch_strobe_q, fetch_strobe_d;
    logic                  trap_taken_q, trap_taken_d;
    logic [FLAGS_W-1:0]    flags;
    logic                  cond;
    logic [U_ADDR_W-1:0]   seq_addr, branch_addr, dispatch_addr, offset_ext;
    logic                  is_call, is_ret, stk_empty;
    logic [U_ADDR_W-1:0]   stk_top;

    assign typ           = seq_typ_e'(typ_i);
    assign flags         = cond_flag_src_i ? u_flags_i : cpu_flags_i;
    assign cond          = flags[cond_sel_i] ^ cond_invert_i;
    assign offset_ext    = U_ADDR_W'($signed(offset_i));
    assign seq_addr      = u_addr_q + 1'b1;
    assign branch_addr   = u_addr_q + offset_ext;
    assign dispatch_addr = (escape_i ? PAGE1_BASE : '0) + (U_ADDR_W'(ir_i) << STEP_W);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        u_addr_d       = seq_addr;
        fetch_strobe_d = 1'b0;
        trap_taken_d   = 1'b0;
        unique case (typ)
            SEQ_NEXT: ;
            SEQ_BRANCH: begin
                if (is_call) begin
                    u_addr_d = branch_addr;
                end else if (is_ret) begin
                    u_addr_d = stk_empty ? FETCH_ADDR : stk_top;
                end else if (cond) begin
                    u_addr_d = branch_addr;
                end
            end
            SEQ_FETCH: begin
                if (irq_pending_i) begin
                    u_addr_d     = TRAP_ADDR;
                    trap_taken_d = 1'b1;
                end else begin
                    u_addr_d       = FETCH_ADDR;
                    fetch_strobe_d = 1'b1;
                end
            end
            SEQ_DISPATCH: u_addr_d = dispatch_addr;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            u_addr_q       <= FETCH_ADDR;
            fetch_strobe_q <= 1'b0;
            trap_taken_q   <= 1'b0;
        end else if (stall_i) begin
            fetch_strobe_q <= 1'b0;
            trap_taken_q   <= 1'b0;
        end else begin
            u_addr_q       <= u_addr_d;
            fetch_strobe_q <= fetch_strobe_d;
            trap_taken_q   <= trap_taken_d;
        end
    end

    assign u_addr_o       = u_addr_q;
    assign fetch_strobe_o = fetch_strobe_q;
    assign trap_taken_o   = trap_taken_q;

`ifdef MICROSEQ_CALL_STACK_EN
    localparam int STK_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [COND_SEL_W-1:0] SEL_CALL = '1;
    localparam logic [COND_SEL_W-1:0] SEL_RET  = SEL_CALL - 1'b1;

    logic [U_ADDR_W-1:0]  stk_q [STACK_DEPTH];
    logic [STK_LVL_W-1:0] stk_level_q, stk_level_d;
    logic                 stk_ovf_q, stk_ovf_d;
    logic                 stk_unf_q, stk_unf_d;
    logic                 stk_full, push_en;

    // CALL/RET reuse the BRANCH encoding with the two top microcode-flag selects.
    assign is_call   = (typ == SEQ_BRANCH) && cond_flag_src_i && (cond_sel_i == SEL_CALL);
    assign is_ret    = (typ == SEQ_BRANCH) && cond_flag_src_i && (cond_sel_i == SEL_RET);
    assign stk_full  = (stk_level_q == STK_LVL_W'(STACK_DEPTH));
    assign stk_empty = (stk_level_q == '0);
    assign stk_top   = stk_q[STK_IDX_W'(stk_level_q - 1'b1)];

    always_comb begin
        stk_level_d = stk_level_q;
        stk_ovf_d   = stk_ovf_q;
        stk_unf_d   = stk_unf_q;
        push_en     = 1'b0;
        if (is_call) begin
            if (stk_full) begin
                stk_ovf_d = 1'b1;
            end else begin
                push_en     = 1'b1;
                stk_level_d = stk_level_q + 1'b1;
            end
        end else if (is_ret) begin
            if (stk_empty) stk_unf_d = 1'b1;
            else           stk_level_d = stk_level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stk_level_q <= '0;
            stk_ovf_q   <= 1'b0;
            stk_unf_q   <= 1'b0;
        end else if (!stall_i) begin
            stk_level_q <= stk_level_d;
            stk_ovf_q   <= stk_ovf_d;
            stk_unf_q   <= stk_unf_d;
        end
    end

    // NOTE: stack storage has no reset; entries above stk_level_q are never read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !stall_i && push_en) begin
            stk_q[STK_IDX_W'(stk_level_q)] <= seq_addr;
        end
    end

    assign stk_level_o = stk_level_q;
    assign stk_ovf_o   = stk_ovf_q;
    assign stk_unf_o   = stk_unf_q;
`else
    assign is_call     = 1'b0;
    assign is_ret      = 1'b0;
    assign stk_empty   = 1'b1;
    assign stk_top     = '0;
    assign stk_level_o = '0;
    assign stk_ovf_o   = 1'b0;
    assign stk_unf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: driver pushes model expectations, a negedge monitor pops and compares.
module tb_microsequencer;

    localparam int CPI = 64;
    localparam int NI  = 256;
    localparam int SD  = 4;
    localparam int FA  = 16;
    localparam int TA  = 32;
    localparam int AW  = 15;
    localparam int M   = 1 << AW;
`ifdef MICROSEQ_CALL_STACK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, cond_invert_i, cond_flag_src_i, escape_i, irq_pending_i;
    logic [1:0]  typ_i;
    logic [6:0]  offset_i;
    logic [3:0]  cond_sel_i;
    logic [7:0]  ir_i;
    logic [15:0] cpu_flags_i, u_flags_i;
    logic [AW-1:0] u_addr_o;
    logic        fetch_strobe_o, trap_taken_o, stk_ovf_o, stk_unf_o;
    logic [2:0]  stk_level_o;

    microsequencer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .typ_i           (typ_i),
        .offset_i        (offset_i),
        .cond_invert_i   (cond_invert_i),
        .cond_flag_src_i (cond_flag_src_i),
        .cond_sel_i      (cond_sel_i),
        .escape_i        (escape_i),
        .ir_i            (ir_i),
        .cpu_flags_i     (cpu_flags_i),
        .u_flags_i       (u_flags_i),
        .irq_pending_i   (irq_pending_i),
        .u_addr_o        (u_addr_o),
        .fetch_strobe_o  (fetch_strobe_o),
        .trap_taken_o    (trap_taken_o),
        .stk_level_o     (stk_level_o),
        .stk_ovf_o       (stk_ovf_o),
        .stk_unf_o       (stk_unf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int u_addr;
        int fetch;
        int trap;
        int level;
        int ovf;
        int unf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model state: address as an integer, stack as a queue of return addresses.
    int m_ua;
    int m_stk[$];
    int m_ovf, m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_push(input string name);
        exp_t e;
        int   off, flags, cond, nxt, fs, tr;
        fs = 0;
        tr = 0;
        if (rst_i) begin
            m_ua = FA;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (!stall_i) begin
            off   = int'($signed(offset_i));
            flags = cond_flag_src_i ? int'(u_flags_i) : int'(cpu_flags_i);
            cond  = ((flags >> cond_sel_i) & 1) ^ int'(cond_invert_i);
            nxt   = m_ua + 1;
            case (typ_i)
                2'b01: begin
                    if (STK_EN && cond_flag_src_i && cond_sel_i == 4'd15) begin
                        if (m_stk.size() < SD) m_stk.push_back((m_ua + 1) % M);
                        else m_ovf = 1;
                        nxt = m_ua + off;
                    end else if (STK_EN && cond_flag_src_i && cond_sel_i == 4'd14) begin
                        if (m_stk.size() > 0) nxt = m_stk.pop_back();
                        else begin
                            nxt   = FA;
                            m_unf = 1;
                        end
                    end else if (cond != 0) begin
                        nxt = m_ua + off;
                    end
                end
                2'b10: begin
                    if (irq_pending_i) begin
                        nxt = TA;
                        tr  = 1;
                    end else begin
                        nxt = FA;
                        fs  = 1;
                    end
                end
                2'b11: nxt = (escape_i ? NI * CPI : 0) + int'(ir_i) * CPI;
                default: ;
            endcase
            m_ua = ((nxt % M) + M) % M;
        end
        e.u_addr = m_ua;
        e.fetch  = fs;
        e.trap   = tr;
        e.level  = m_stk.size();
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic idle();
        rst_i           = 1'b0;
        stall_i         = 1'b0;
        typ_i           = 2'b00;
        offset_i        = '0;
        cond_invert_i   = 1'b0;
        cond_flag_src_i = 1'b0;
        cond_sel_i      = '0;
        escape_i        = 1'b0;
        ir_i            = '0;
        cpu_flags_i     = '0;
        u_flags_i       = '0;
        irq_pending_i   = 1'b0;
    endtask

    task automatic cycle(input string name);
        model_push(name);
        @(posedge clk_i);
        #1;
    endtask

    task automatic goto_addr(input int ir, input bit esc, input int steps);
        idle();
        typ_i    = 2'b11;
        ir_i     = 8'(ir);
        escape_i = esc;
        cycle("dispatch");
        idle();
        for (int i = 0; i < steps; i++) cycle("next");
    endtask

    task automatic call_ret(input bit is_call, input int off, input string name);
        idle();
        typ_i           = 2'b01;
        cond_flag_src_i = 1'b1;
        cond_sel_i      = is_call ? 4'd15 : 4'd14;
        offset_i        = 7'(off);
        cycle(name);
    endtask

    initial begin : monitor
        exp_t  e;
        string n;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, " u_addr"},    u_addr_o,       e.u_addr);
                check({n, " fetch"},     fetch_strobe_o, e.fetch);
                check({n, " trap"},      trap_taken_o,   e.trap);
                check({n, " stk_level"}, stk_level_o,    e.level);
                check({n, " stk_ovf"},   stk_ovf_o,      e.ovf);
                check({n, " stk_unf"},   stk_unf_o,      e.unf);
            end
        end
    end

    initial begin : driver
        m_ua  = FA;
        m_ovf = 0;
        m_unf = 0;

        idle();
        rst_i         = 1'b1;
        stall_i       = 1'b1;
        typ_i         = 2'b10;
        irq_pending_i = 1'b1;
        cycle("reset0");
        cycle("reset1");

        idle();
        typ_i = 2'b11;
        ir_i  = 8'h05;
        cycle("dispatch p0");
        escape_i = 1'b1;
        cycle("dispatch p1");

        goto_addr(1, 1'b0, 36);
        typ_i       = 2'b01;
        cond_sel_i  = 4'd3;
        cpu_flags_i = 16'h0008;
        offset_i    = 7'h7E;
        cycle("branch taken");
        idle();
        cycle("next");
        cycle("next");
        typ_i         = 2'b01;
        cond_sel_i    = 4'd3;
        cpu_flags_i   = 16'h0008;
        offset_i      = 7'h7E;
        cond_invert_i = 1'b1;
        cycle("branch not taken");

        goto_addr(255, 1'b1, 63);
        cycle("wrap");

        idle();
        typ_i         = 2'b10;
        irq_pending_i = 1'b1;
        cycle("trap");
        idle();
        cycle("after trap");
        typ_i = 2'b10;
        cycle("fetch");
        idle();
        cycle("after fetch");

        for (int i = 0; i < 4; i++) begin
            idle();
            stall_i       = 1'b1;
            typ_i         = 2'b10;
            irq_pending_i = i[0];
            cycle("stall");
        end

        goto_addr(0, 1'b0, 16);

        goto_addr(3, 1'b0, 8);
        call_ret(1'b1, 10, "call");
        call_ret(1'b0, 0, "ret");

        for (int i = 0; i < 5; i++) call_ret(1'b1, 1, "nested call");
        for (int i = 0; i < 5; i++) call_ret(1'b0, 0, "nested ret");
        idle();
        for (int i = 0; i < 3; i++) cycle("sticky");

        idle();
        rst_i = 1'b1;
        cycle("clear");
        call_ret(1'b1, 20, "pre-reset call");
        call_ret(1'b1, 20, "pre-reset call");
        idle();
        rst_i = 1'b1;
        cycle("mid-sub reset");
        call_ret(1'b0, 0, "ret after reset");

        for (int i = 0; i < 1500; i++) begin
            idle();
            rst_i           = ($urandom_range(0, 99) == 0);
            stall_i         = ($urandom_range(0, 7) == 0);
            typ_i           = 2'($urandom_range(0, 3));
            offset_i        = 7'($urandom);
            cond_invert_i   = 1'($urandom);
            cond_flag_src_i = 1'($urandom);
            cond_sel_i      = 4'($urandom);
            escape_i        = 1'($urandom);
            ir_i            = 8'($urandom);
            cpu_flags_i     = 16'($urandom);
            u_flags_i       = 16'($urandom);
            irq_pending_i   = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                typ_i           = 2'b01;
                cond_flag_src_i = 1'b1;
                cond_sel_i      = 4'(14 + $urandom_range(0, 1));
            end
            cycle("random");
        end

        idle();
        rst_i = 1'b1;
        cycle("final reset");
        idle();
        cycle("final next");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clk_i);
            #1;
        end
        check("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
